// File: rtl/bcd_serial_adder_ctrl.sv
// Multi-digit packed-BCD adder controller: one decimal digit per clock with a chained carry.
// Optional BCD_DIGIT_CHECK_EN flags captured operand digits above 9 on err.
module bcd_serial_adder_ctrl #(
  parameter int unsigned DIGITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                in_ready,
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  input  logic                cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] sum,
  output logic                cout,
  output logic                busy,
  output logic                err
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SW = IW + 2;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  a_q;
  logic [W-1:0]  b_q;
  logic [IW-1:0] idx;
  logic          carry;

  logic [SW-1:0] shift;
  logic [3:0]    dig_a;
  logic [3:0]    dig_b;
  logic [3:0]    dig_s;
  logic [4:0]    raw;
  logic          carry_nxt;
  logic          last;

  // One-digit add-and-correct stage, steered by the digit index
  always_comb begin
    shift = {idx, 2'b00};
    dig_a = 4'(a_q >> shift);
    dig_b = 4'(b_q >> shift);
    raw   = 5'(dig_a) + 5'(dig_b) + 5'(carry);
    dig_s = raw[3:0];
    carry_nxt = 1'b0;
    if (raw > 5'd9) begin
      dig_s     = 4'(raw + 5'd6);
      carry_nxt = 1'b1;
    end
    last = (idx == IW'(DIGITS - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
`ifdef BCD_DIGIT_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_q      <= a;
            b_q      <= b;
            carry    <= cin;
            sum      <= '0;
            idx      <= '0;
`ifdef BCD_DIGIT_CHECK_EN
            err      <= 1'b0;
`endif
            state    <= ADD;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ADD: begin
          // Replace only the current digit slot of the result
          sum   <= (sum & ~(W'(4'hF) << shift)) | (W'(dig_s) << shift);
          carry <= carry_nxt;
`ifdef BCD_DIGIT_CHECK_EN
          if ((dig_a > 4'd9) || (dig_b > 4'd9)) begin
            err <= 1'b1;
          end
`endif
          if (last) begin
            cout      <= carry_nxt;
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

`ifndef BCD_DIGIT_CHECK_EN
  assign err = 1'b0;
`endif

endmodule
